// File: rtl/fft32_seq_ctrl.sv
// fft32_seq_ctrl
//   Address/strobe sequencer for a memory-based 32-point radix-2 DIF FFT
//   built around one shared, pipelined butterfly. It loads 32 samples into
//   an external RAM, issues 5 stages x 16 butterflies, writes results back
//   in place after BF_LAT cycles, then unloads the 32 results.
//
// Parameters
//   BF_LAT     cycles from bf_issue to the matching wb_en (legal 1..8)
//
// Compile-time option
//   FFT_OUT_BITREV_EN  defined: ul_addr = bitrev5(u), natural frequency order
//                      undefined: ul_addr = u, DIF bit-reversed order
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   start                    begin a transform (sampled only in IDLE)
//   busy, done               not-IDLE flag, one-cycle completion pulse
//   ld_valid/ld_ready/ld_addr         sample load handshake and RAM address
//   bf_issue/bf_addr_a/bf_addr_b      butterfly read strobe and addresses
//   bf_tw_idx/bf_stage                twiddle index k (W32^k) and stage
//   wb_en/wb_addr_a/wb_addr_b         delayed write-back strobe/addresses
//   ul_valid/ul_ready/ul_addr/ul_last result unload handshake
module fft32_seq_ctrl #(
    parameter int unsigned BF_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic       ld_valid,
    output logic       ld_ready,
    output logic [4:0] ld_addr,
    output logic       bf_issue,
    output logic [4:0] bf_addr_a,
    output logic [4:0] bf_addr_b,
    output logic [3:0] bf_tw_idx,
    output logic [2:0] bf_stage,
    output logic       wb_en,
    output logic [4:0] wb_addr_a,
    output logic [4:0] wb_addr_b,
    output logic       ul_valid,
    input  logic       ul_ready,
    output logic [4:0] ul_addr,
    output logic       ul_last
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        UNLOAD
    } state_t;

    state_t     state;
    logic [4:0] n;       // load count
    logic [3:0] j;       // butterfly index within a stage
    logic [2:0] s;       // stage
    logic [3:0] dcnt;    // drain cycle count
    logic [4:0] u;       // unload count
    logic       done_r;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            n      <= '0;
            j      <= '0;
            s      <= '0;
            dcnt   <= '0;
            u      <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        n     <= '0;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        n <= n + 5'd1;
                        if (n == 5'd31) begin
                            state <= RUN;
                            s     <= '0;
                            j     <= '0;
                        end
                    end
                end
                RUN: begin
                    j <= j + 4'd1;
                    if (j == 4'd15) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end
                end
                DRAIN: begin
                    dcnt <= dcnt + 4'd1;
                    // Last write-back of this stage lands in the final drain cycle.
                    if (dcnt == 4'(BF_LAT - 1)) begin
                        if (s == 3'd4) begin
                            state <= UNLOAD;
                            s     <= '0;
                            u     <= '0;
                        end else begin
                            state <= RUN;
                            s     <= s + 3'd1;
                            j     <= '0;
                        end
                    end
                end
                UNLOAD: begin
                    if (ul_ready) begin
                        u <= u + 5'd1;
                        if (u == 5'd31) begin
                            state  <= IDLE;
                            done_r <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Butterfly address generation
    //   span = 16>>s; a = 2*span*(j/span) + j%span, computed by keeping the
    //   low log2(span) bits of j in place and shifting the group bits up one.
    // ------------------------------------------------------------------
    logic       run;
    logic [4:0] span;
    logic [4:0] mask;
    logic [4:0] jj;
    logic [4:0] k;
    logic [4:0] addr_a_c;
    logic [4:0] addr_b_c;
    logic [3:0] tw_c;

    always_comb begin
        span     = 5'd16 >> s;
        mask     = span - 5'd1;
        jj       = {1'b0, j};
        k        = jj & mask;
        addr_a_c = ((jj & ~mask) << 1) | k;
        addr_b_c = addr_a_c + span;
        tw_c     = k[3:0] << s;
    end

    assign run       = (state == RUN);
    assign bf_issue  = run;
    assign bf_addr_a = run ? addr_a_c : '0;
    assign bf_addr_b = run ? addr_b_c : '0;
    assign bf_tw_idx = run ? tw_c : '0;
    assign bf_stage  = run ? s : '0;

    // ------------------------------------------------------------------
    // Write-back delay line of {issue, addr_a, addr_b}, BF_LAT deep.
    // Held as one flat vector so BF_LAT=1 needs no special case.
    // ------------------------------------------------------------------
    localparam int unsigned W = 11;

    logic [W*BF_LAT-1:0]     dly;
    logic [W*(BF_LAT+1)-1:0] dly_ext;
    logic [W-1:0]            dly_out;

    assign dly_ext = {dly, bf_issue, bf_addr_a, bf_addr_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly <= '0;
        end else begin
            dly <= dly_ext[W*BF_LAT-1:0];
        end
    end

    assign dly_out   = dly[W*BF_LAT-1 -: W];
    assign wb_en     = dly_out[10];
    assign wb_addr_a = dly_out[9:5];
    assign wb_addr_b = dly_out[4:0];

    // ------------------------------------------------------------------
    // Load / unload / status
    // ------------------------------------------------------------------
    logic [4:0] ul_sel;

`ifdef FFT_OUT_BITREV_EN
    assign ul_sel = {u[0], u[1], u[2], u[3], u[4]};
`else
    assign ul_sel = u;
`endif

    assign busy     = (state != IDLE);
    assign done     = done_r;
    assign ld_ready = (state == LOAD);
    assign ld_addr  = ld_ready ? n : '0;
    assign ul_valid = (state == UNLOAD);
    assign ul_addr  = ul_valid ? ul_sel : '0;
    assign ul_last  = ul_valid && (u == 5'd31);

endmodule

// File: tb/tb_fft32_seq_ctrl.sv
// tb_fft32_seq_ctrl
//   Scoreboard bench for fft32_seq_ctrl. Two instances (BF_LAT=2 and
//   BF_LAT=5) share the stimulus. The stimulus pushes the expected load,
//   butterfly, write-back and unload sequences, derived from the DIF
//   butterfly enumeration (stage, group, offset), into per-instance queues;
//   a negedge monitor pops and compares whenever an instance presents a
//   handshake or strobe, including the cycle at which it appears.
module tb_fft32_seq_ctrl;

    localparam int unsigned L0 = 2;
    localparam int unsigned L1 = 5;

    typedef struct {
        int unsigned s;
        int unsigned j;
        int unsigned a;
        int unsigned b;
        int unsigned tw;
    } bf_t;

    typedef struct {
        int unsigned addr;
        bit          last;
    } ul_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    logic ld_valid;
    logic ul_ready;

    logic       busy      [2];
    logic       done      [2];
    logic       ld_ready  [2];
    logic [4:0] ld_addr   [2];
    logic       bf_issue  [2];
    logic [4:0] bf_addr_a [2];
    logic [4:0] bf_addr_b [2];
    logic [3:0] bf_tw_idx [2];
    logic [2:0] bf_stage  [2];
    logic       wb_en     [2];
    logic [4:0] wb_addr_a [2];
    logic [4:0] wb_addr_b [2];
    logic       ul_valid  [2];
    logic [4:0] ul_addr   [2];
    logic       ul_last   [2];

    fft32_seq_ctrl #(.BF_LAT(L0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy[0]), .done(done[0]),
        .ld_valid(ld_valid), .ld_ready(ld_ready[0]), .ld_addr(ld_addr[0]),
        .bf_issue(bf_issue[0]), .bf_addr_a(bf_addr_a[0]), .bf_addr_b(bf_addr_b[0]),
        .bf_tw_idx(bf_tw_idx[0]), .bf_stage(bf_stage[0]),
        .wb_en(wb_en[0]), .wb_addr_a(wb_addr_a[0]), .wb_addr_b(wb_addr_b[0]),
        .ul_valid(ul_valid[0]), .ul_ready(ul_ready), .ul_addr(ul_addr[0]),
        .ul_last(ul_last[0])
    );

    fft32_seq_ctrl #(.BF_LAT(L1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy[1]), .done(done[1]),
        .ld_valid(ld_valid), .ld_ready(ld_ready[1]), .ld_addr(ld_addr[1]),
        .bf_issue(bf_issue[1]), .bf_addr_a(bf_addr_a[1]), .bf_addr_b(bf_addr_b[1]),
        .bf_tw_idx(bf_tw_idx[1]), .bf_stage(bf_stage[1]),
        .wb_en(wb_en[1]), .wb_addr_a(wb_addr_a[1]), .wb_addr_b(wb_addr_b[1]),
        .ul_valid(ul_valid[1]), .ul_ready(ul_ready), .ul_addr(ul_addr[1]),
        .ul_last(ul_last[1])
    );

    // Scoreboard state
    int unsigned exp_ld [2][$];
    bf_t         exp_bf [2][$];
    bf_t         exp_wb [2][$];
    ul_t         exp_ul [2][$];

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint t_ld     [2] = '{-1, -1};
    longint done_cyc [2] = '{-1, -1};
    bit     idle_chk = 1'b0;

    function automatic longint lat(input bit idx);
        return idx ? longint'(L1) : longint'(L0);
    endfunction

    task automatic chk(input string name, input bit idx,
                       input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h",
                     name, idx, cyc, got, want);
        end
    endtask

    task automatic unexp(input string name, input bit idx);
        checks++;
        errors++;
        $display("FAIL %s dut%0d cycle %0d: event with no expected entry", name, idx, cyc);
    endtask

    // ------------------------------------------------------------------
    // Reference model: expected sequences for one full transform
    // ------------------------------------------------------------------
    task automatic push_expected(input bit idx);
        bf_t e;
        ul_t w;
        int unsigned span;
        int unsigned r;
        for (int unsigned n = 0; n < 32; n++) exp_ld[idx].push_back(n);
        for (int unsigned s = 0; s < 5; s++) begin
            span = 16 >> s;
            for (int unsigned g = 0; g < (32 / (2 * span)); g++) begin
                for (int unsigned k = 0; k < span; k++) begin
                    e.s  = s;
                    e.j  = g * span + k;
                    e.a  = g * 2 * span + k;
                    e.b  = e.a + span;
                    e.tw = k * (1 << s);
                    exp_bf[idx].push_back(e);
                    exp_wb[idx].push_back(e);
                end
            end
        end
        for (int unsigned uu = 0; uu < 32; uu++) begin
`ifdef FFT_OUT_BITREV_EN
            r = 0;
            for (int unsigned bit_i = 0; bit_i < 5; bit_i++)
                if (((uu >> bit_i) & 1) == 1) r = r + (16 >> bit_i);
`else
            r = uu;
`endif
            w.addr = r;
            w.last = (uu == 31);
            exp_ul[idx].push_back(w);
        end
    endtask

    task automatic flush_expected();
        for (int i = 0; i < 2; i++) begin
            exp_ld[i].delete();
            exp_bf[i].delete();
            exp_wb[i].delete();
            exp_ul[i].delete();
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    task automatic mon(input bit i);
        int unsigned n;
        bf_t         e;
        ul_t         w;
        longint      t_issue;
        if (!rst_n) begin
            chk("reset_outputs", i,
                64'({busy[i], done[i], ld_ready[i], ld_addr[i], bf_issue[i],
                     bf_addr_a[i], bf_addr_b[i], bf_tw_idx[i], bf_stage[i],
                     wb_en[i], wb_addr_a[i], wb_addr_b[i], ul_valid[i],
                     ul_addr[i], ul_last[i]}),
                64'd0);
            t_ld[i]     = -1;
            done_cyc[i] = -1;
            return;
        end
        if (ld_ready[i] && ld_valid) begin
            if (exp_ld[i].size() == 0) unexp("ld_handshake", i);
            else begin
                n = exp_ld[i].pop_front();
                chk("ld_addr", i, 64'(ld_addr[i]), 64'(n));
                if (n == 31) t_ld[i] = cyc;
            end
        end
        if (bf_issue[i]) begin
            if (exp_bf[i].size() == 0) unexp("bf_issue", i);
            else begin
                e = exp_bf[i].pop_front();
                t_issue = t_ld[i] + 1 + longint'(e.s) * (16 + lat(i)) + longint'(e.j);
                chk("bf_issue_cycle", i, 64'(cyc), 64'(t_issue));
                chk("bf_stage_a_b_tw", i,
                    64'({bf_stage[i], bf_addr_a[i], bf_addr_b[i], bf_tw_idx[i]}),
                    64'({3'(e.s), 5'(e.a), 5'(e.b), 4'(e.tw)}));
            end
        end
        if (wb_en[i]) begin
            if (exp_wb[i].size() == 0) unexp("wb_en", i);
            else begin
                e = exp_wb[i].pop_front();
                t_issue = t_ld[i] + 1 + longint'(e.s) * (16 + lat(i)) + longint'(e.j);
                chk("wb_cycle", i, 64'(cyc), 64'(t_issue + lat(i)));
                chk("wb_addr", i, 64'({wb_addr_a[i], wb_addr_b[i]}),
                    64'({5'(e.a), 5'(e.b)}));
            end
        end
        if (ul_valid[i] && ul_ready) begin
            if (exp_ul[i].size() == 0) unexp("ul_handshake", i);
            else begin
                w = exp_ul[i].pop_front();
                chk("ul_addr_last", i, 64'({ul_addr[i], ul_last[i]}),
                    64'({5'(w.addr), w.last}));
                if (w.last) done_cyc[i] = cyc + 1;
            end
        end
        if (cyc == done_cyc[i]) begin
            chk("done_pulse_busy", i, 64'({done[i], busy[i]}), 64'(2'b10));
            chk("leftover_expected", i,
                64'(exp_ld[i].size() + exp_bf[i].size() + exp_wb[i].size() + exp_ul[i].size()),
                64'd0);
            done_cyc[i] = -1;
        end else if (done[i]) begin
            unexp("done", i);
        end
        if (idle_chk) chk("idle_busy", i, 64'(busy[i]), 64'd0);
    endtask

    always @(negedge clk) begin
        cyc++;
        mon(1'b0);
        mon(1'b1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // mode 0: fixed load gap at n=10, ul_ready toggling 1,0,1,...
    // mode 1: random ld_valid / ul_ready, stray start pulse during RUN
    // mode 2: random load, then reset during stage 2 drain of dut0
    task automatic run_xform(input int unsigned mode);
        int unsigned cnt;
        int unsigned gap;
        bit          v;
        bit          tog;
        bit          found;
        bit          finished;
        push_expected(1'b0);
        push_expected(1'b1);
        idle_chk = 1'b0;
        ul_ready = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt = 0;
        gap = 3;
        while (cnt < 32) begin
            if (mode == 0) begin
                v = (cnt != 10) || (gap == 0);
                if (!v) gap--;
            end else begin
                v = ($urandom_range(0, 3) != 0);
            end
            ld_valid = v;
            @(posedge clk);
            #1;
            if (v) cnt++;
        end
        ld_valid = 1'b0;

        if (mode == 2) begin
            found = 1'b0;
            v     = 1'b0;
            for (int c = 0; c < 300 && !found; c++) begin
                @(negedge clk);
                if (bf_issue[0] && bf_stage[0] == 3'd2) v = 1'b1;
                else if (v && !bf_issue[0]) found = 1'b1;
            end
            if (!found) begin
                checks++;
                errors++;
                $display("FAIL abort_wait: stage 2 drain of dut0 not reached");
            end
            #2;
            rst_n = 1'b0;
            flush_expected();
            repeat (3) @(posedge clk);
            #1;
            rst_n    = 1'b1;
            idle_chk = 1'b1;
            repeat (12) @(posedge clk);
            #1;
            return;
        end

        tog      = 1'b1;
        finished = 1'b0;
        for (int c = 0; c < 1500 && !finished; c++) begin
            if (mode == 0) begin
                ul_ready = tog;
                tog      = ~tog;
            end else begin
                ul_ready = 1'($urandom_range(0, 1));
            end
            start = (mode == 1) && (c == 20);
            @(posedge clk);
            #1;
            if (!busy[0] && !busy[1]) finished = 1'b1;
        end
        start    = 1'b0;
        ul_ready = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL transform_timeout: busy still high after cycle budget");
        end
        idle_chk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        ld_valid = 1'b0;
        ul_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        idle_chk = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        run_xform(0);
        run_xform(1);
        run_xform(1);
        run_xform(2);
        run_xform(1);
        run_xform(0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
